ram_dma: RTL
============

# ram_dma

Block-transfer engine that drives the write port and one read port of the CPU32 dual-port RAM. It copies `len` words from `src` to `dst`, or fills `len` words at `dst` with a constant, at one word per clock. It sits beside the CPU as a second RAM initiator; the top level muxes its RAM-side outputs with the CPU's while `busy` is high.

## Interface
- `N_RAM_P`, default `` `N_RAM ``: RAM depth in words; pointers wrap modulo this value.
- `W`, default `` `B_WORD `` (32): data, address and length width.
- `clk_cpu` in 1: the one clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 1: 0 = copy, 1 = fill.
- `src` in W: source word address (copy only).
- `dst` in W: destination word address.
- `len` in W: word count.
- `fill_data` in W: fill value (fill only).
- `abort` in 1: stop the transfer after the current cycle.
- `busy` out 1: high while in RUN.
- `done` out 1: single-cycle completion pulse.
- `count` out W: words written so far in the current or last transfer.
- `rd_adrs` out W: RAM read address.
- `wr_adrs` out W: RAM write address.
- `wr_data` out W: RAM write data.
- `wr_en` out 1: RAM write enable.
- `q` in W: RAM read data; combinational from `rd_adrs`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 latches `src`, `dst`, `len`, `fill_data` and `op` into registers and clears `count`.
  - If `len`≠0, go to RUN; if `len`=0, go to DONE.
- RUN, each cycle:
  - `rd_adrs`=src_ptr, `wr_adrs`=dst_ptr, `wr_en`=1.
  - `wr_data` = `q` for copy, or the latched fill value for fill.
  - At the clock edge: both pointers advance by 1, `count` increments, and the remaining count decrements.
  - When remaining reaches 0 after a write, go to DONE.
- Pointer increment: if ptr = `N_RAM_P`−1, next ptr is 0; otherwise ptr+1. Inputs ≥ `N_RAM_P` are reduced modulo `N_RAM_P` when latched.
- `abort`=1 in RUN: the current cycle's write still occurs, then the state goes to DONE. `count` reflects the writes actually performed.
- DONE: `done`=1 for one cycle, then IDLE. `start` is ignored in DONE.
- `start` in RUN or DONE is ignored; there is no queueing.
- Overlap: the copy is strictly forward and word-by-word, and each read sees all earlier writes. With dst = src+1, every destination word receives the original `src[0]`. Overlapping memmove is not supported.
- Outside RUN: `wr_en`=0, and `rd_adrs`, `wr_adrs`, `wr_data` are 0.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `count`=0, `wr_en`=0, `rd_adrs`=`wr_adrs`=`wr_data`=0; all internal registers 0.
- With `start` sampled at edge E0:
  - RUN spans the cycles after E0 through E`len`, with writes committed at edges E1..E`len`.
  - `done` is high in the cycle after E`len`.
  - `busy` is high for exactly `len` cycles.
- `len`=0: `done` is high in the cycle after E0; no write occurs.
- Throughput is one word per cycle. `wr_data` in copy mode is a same-cycle combinational path from `q`.
- Reset asserted mid-transfer: returns to IDLE immediately and outputs take their reset values. RAM words already written remain written.

## Configuration
- `RAM_DMA_FILL_EN` defined: `op` and `fill_data` are honoured.
- `RAM_DMA_FILL_EN` undefined:
  - The fill register and fill mux are not built.
  - `op` and `fill_data` are ignored; every transfer is a copy.
  - The ports remain present.

## Test plan
- Copy: RAM[0..3]=A,B,C,D; start, src=0, dst=16, len=4 → writes at 16,17,18,19 = A,B,C,D on 4 consecutive edges; `busy` high 4 cycles; `done` 1 cycle later; `count`=4.
- Fill (with `RAM_DMA_FILL_EN`): dst=8, len=3, fill_data=0xDEADBEEF → RAM[8..10]=0xDEADBEEF. Without the macro, the same stimulus copies from `src`.
- Wrap: N_RAM_P=32, src=30, dst=0, len=4 → reads 30,31,0,1. Overlapping forward copy with src=0, dst=1, len=3 and RAM[0]=5 → RAM[1..3]=5.
- len=0 → no `wr_en`; `busy` never rises; `done` is high in the cycle after start.
- Abort during the 2nd RUN cycle of len=10 → exactly 2 writes, `count`=2, `done` pulses next, `start` ignored while busy.
- Reset asserted mid-RUN of len=8 → all outputs 0 asynchronously, state IDLE; a new transfer starts cleanly afterwards.

Source files
------------

// File: rtl/ram_dma_if.sv
// ram_dma_if: control, status and RAM-side signals of the ram_dma block-transfer engine.
// slave is the engine side; master is the initiator/RAM side that drives requests and q.
interface ram_dma_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic         op;
  logic [W-1:0] src;
  logic [W-1:0] dst;
  logic [W-1:0] len;
  logic [W-1:0] fill_data;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] count;
  logic [W-1:0] rd_adrs;
  logic [W-1:0] wr_adrs;
  logic [W-1:0] wr_data;
  logic         wr_en;
  logic [W-1:0] q;

  modport slave (
    input  start, op, src, dst, len, fill_data, abort, q,
    output busy, done, count, rd_adrs, wr_adrs, wr_data, wr_en
  );

  modport master (
    output start, op, src, dst, len, fill_data, abort, q,
    input  busy, done, count, rd_adrs, wr_adrs, wr_data, wr_en
  );
endinterface

// File: rtl/ram_dma.sv
// ram_dma: word-per-cycle copy/fill engine driving the write port and one read port
// of the dual-port RAM. Optional fill mode is built only when RAM_DMA_FILL_EN is defined;
// without it op/fill_data are ignored and every transfer is a copy.
`ifndef B_WORD
`define B_WORD 32
`endif
`ifndef N_RAM
`define N_RAM 256
`endif

module ram_dma #(
  parameter int unsigned N_RAM_P = `N_RAM,
  parameter int unsigned W       = `B_WORD
) (
  input  logic     clk_cpu,
  input  logic     reset,
  ram_dma_if.slave bus
);

  localparam logic [W-1:0] DEPTH    = W'(N_RAM_P);
  localparam logic [W-1:0] LAST_PTR = W'(N_RAM_P - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] src_ptr_q, src_ptr_d;
  logic [W-1:0] dst_ptr_q, dst_ptr_d;
  logic [W-1:0] remain_q, remain_d;
  logic [W-1:0] count_q, count_d;

`ifdef RAM_DMA_FILL_EN
  logic         op_q, op_d;
  logic [W-1:0] fill_q, fill_d;
`else
  logic         unused_fill;
  assign unused_fill = ^{bus.op, bus.fill_data};
`endif

  // Pointer advance with wrap at the top of the RAM.
  function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + W'(1);
  endfunction

  // State and datapath registers; reset drops any transfer in flight.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      remain_q  <= '0;
      count_q   <= '0;
`ifdef RAM_DMA_FILL_EN
      op_q      <= 1'b0;
      fill_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      remain_q  <= remain_d;
      count_q   <= count_d;
`ifdef RAM_DMA_FILL_EN
      op_q      <= op_d;
      fill_q    <= fill_d;
`endif
    end
  end

  // Next-state, register updates and RAM-side outputs.
  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remain_d    = remain_q;
    count_d     = count_q;
`ifdef RAM_DMA_FILL_EN
    op_d        = op_q;
    fill_d      = fill_q;
`endif
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_adrs = '0;
    bus.wr_adrs = '0;
    bus.wr_data = '0;
    bus.count   = count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_ptr_d = bus.src % DEPTH;
          dst_ptr_d = bus.dst % DEPTH;
          remain_d  = bus.len;
          count_d   = '0;
`ifdef RAM_DMA_FILL_EN
          op_d      = bus.op;
          fill_d    = bus.fill_data;
`endif
          state_d   = (bus.len == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        bus.busy    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.rd_adrs = src_ptr_q;
        bus.wr_adrs = dst_ptr_q;
`ifdef RAM_DMA_FILL_EN
        bus.wr_data = op_q ? fill_q : bus.q;
`else
        bus.wr_data = bus.q;
`endif
        src_ptr_d = ptr_inc(src_ptr_q);
        dst_ptr_d = ptr_inc(dst_ptr_q);
        count_d   = count_q + W'(1);
        remain_d  = remain_q - W'(1);
        // The write in this cycle always commits; abort only cuts the tail.
        if (remain_q == W'(1) || bus.abort) state_d = S_DONE;
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
